// File: rtl/f_pkg.sv
// Shared types and constants for the FCLASS scheduling slice: class mask width,
// integer XLEN, result entry layout and output-buffer occupancy encoding.
package f_pkg;
  localparam int CLASS_W    = 10;
  localparam int XLEN       = 64;
  localparam int TAG_W_DFLT = 5;

  typedef struct packed {
    logic                  lane;
    logic [TAG_W_DFLT-1:0] tag;
    logic [CLASS_W-1:0]    cls;
  } f_cls_entry_t;

  typedef enum logic [1:0] {OB_EMPTY, OB_PART, OB_FULL} ob_state_e;
endpackage

// File: rtl/f_class.sv
// Combinational RISC-V FCLASS on a recoded (33/65-bit) float operand.
// Exponent top bits: 000 zero, 110 infinity, 111 NaN; below min-normal is subnormal.
module f_class
  import f_pkg::*;
(
  input  logic [64:0]        rec_fn,
  input  logic               fp64,
  output logic [CLASS_W-1:0] cls
);
  logic        sign;
  logic        is_zero;
  logic        is_special;
  logic        is_nan;
  logic        is_inf;
  logic        is_sub;
  logic        is_norm;
  logic        sig_msb;
  logic [11:0] exp_d64;
  logic [8:0]  exp_s32;
  logic        unused_bits;

  assign exp_d64     = rec_fn[63:52];
  assign exp_s32     = rec_fn[31:23];
  assign unused_bits = ^{rec_fn[50:33], rec_fn[21:0]};

  always_comb begin
    if (fp64) begin
      sign       = rec_fn[64];
      is_zero    = (exp_d64[11:9] == 3'b000);
      is_special = (exp_d64[11:10] == 2'b11);
      is_nan     = is_special & exp_d64[9];
      is_sub     = !is_zero && (exp_d64 < 12'd1026);
      sig_msb    = rec_fn[51];
    end else begin
      sign       = rec_fn[32];
      is_zero    = (exp_s32[8:6] == 3'b000);
      is_special = (exp_s32[8:7] == 2'b11);
      is_nan     = is_special & exp_s32[6];
      is_sub     = !is_zero && (exp_s32 < 9'd130);
      sig_msb    = rec_fn[22];
    end
    is_inf  = is_special & !is_nan;
    is_norm = !is_zero & !is_special & !is_sub;

    cls    = '0;
    cls[0] = sign & is_inf;
    cls[1] = sign & is_norm;
    cls[2] = sign & is_sub;
    cls[3] = sign & is_zero;
    cls[4] = !sign & is_zero;
    cls[5] = !sign & is_sub;
    cls[6] = !sign & is_norm;
    cls[7] = !sign & is_inf;
    cls[8] = is_nan & !sig_msb;
    cls[9] = is_nan & sig_msb;
  end
endmodule

// File: rtl/f_class_obuf.sv
// Small circular result buffer with push/pop/flush and a combinational head.
// Depth need not be a power of two, so pointers wrap by compare.
module f_class_obuf
  import f_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output ob_state_e    state
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity comes from count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);

  always_comb begin
    state = OB_PART;
    if (count_q == '0)           state = OB_EMPTY;
    else if (count_q == FULL_CNT) state = OB_FULL;
  end
endmodule

// File: rtl/f_class_sched.sv
// Round-robin sharing of one FCLASS unit between two FPU issue lanes; results are
// buffered and drained to integer writeback over valid/ready.
module f_class_sched
  import f_pkg::*;
#(
  parameter int TAG_W      = 5,
  parameter int OBUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [64:0]      req0_rec_fn,
  input  logic             req0_fp64,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [64:0]      req1_rec_fn,
  input  logic             req1_fp64,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic             wb_lane,
  output logic [TAG_W-1:0] wb_tag,
  output logic [63:0]      wb_data,
  output logic             busy
);
  typedef struct packed {
    logic               lane;
    logic [TAG_W-1:0]   tag;
    logic [CLASS_W-1:0] cls;
  } sched_entry_t;

  logic               rr_q, rr_d;
  logic               grant0, grant1, push, pop, space;
  logic               head_valid;
  ob_state_e          ob_state;
  logic [64:0]        sel_rec_fn;
  logic               sel_fp64;
  logic [CLASS_W-1:0] cls;
  sched_entry_t       push_entry, head_entry;

  always_comb begin
    pop    = head_valid & wb_ready;
    space  = (ob_state != OB_FULL) | pop;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (space && !flush && !rst) begin
      if (req0_valid && (!req1_valid || !rr_q)) grant0 = 1'b1;
      else if (req1_valid)                      grant1 = 1'b1;
    end
    push = grant0 | grant1;
    rr_d = rr_q;
    if (grant0)      rr_d = 1'b1;
    else if (grant1) rr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end

  assign sel_rec_fn = grant1 ? req1_rec_fn : req0_rec_fn;
  assign sel_fp64   = grant1 ? req1_fp64 : req0_fp64;
  assign push_entry = '{lane: grant1, tag: (grant1 ? req1_tag : req0_tag), cls: cls};

  f_class u_class (
    .rec_fn (sel_rec_fn),
    .fp64   (sel_fp64),
    .cls    (cls)
  );

  f_class_obuf #(
    .DEPTH (OBUF_DEPTH),
    .W     ($bits(sched_entry_t))
  ) u_obuf (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head_data  (head_entry),
    .head_valid (head_valid),
    .state      (ob_state)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign wb_valid   = head_valid;
  assign busy       = head_valid;
  assign wb_lane    = head_entry.lane;
  assign wb_tag     = head_entry.tag;
  assign wb_data    = {{(XLEN - CLASS_W){1'b0}}, head_entry.cls};
endmodule
